// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types and constants for the data memory arbiter
package dm_arb_pkg;

  // Arbiter FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RWAIT = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Port indices: port 0 is the CPU LD/STS path, port 1 the DMA/debug loader
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  // Arbitration modes
  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// rtl/data_mem_arbiter_rr_arb2.sv - combinational two-way arbiter with one-hot grant
module rr_arb2
  import dm_arb_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  // Single requester always wins; on a tie, fixed mode favours port 0,
  // round-robin mode favours whichever port was not granted last.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        if (PRIO_MODE == PRIO_FIXED) gnt = 2'b01;
        else if (last_gnt == PORT_DMA) gnt = 2'b01;
        else gnt = 2'b10;
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - shares a single-port data memory between CPU and DMA requesters
module data_mem_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  output logic              gnt0_o,
  output logic              rvalid0_o,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt1_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o,
  output logic              en_DM_rd,
  output logic              en_DM_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t      state;
  logic        winner;
  logic        last_gnt;
  logic [1:0]  pick;
  logic        sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 #(
    .PRIO_MODE (PRIO_MODE)
  ) u_arb (
    .req      ({req1_i, req0_i}),
    .last_gnt (last_gnt),
    .gnt      (pick)
  );

  // Route the winning port's command fields toward the command registers
  always_comb begin
    sel_we    = we0_i;
    sel_addr  = addr0_i;
    sel_wdata = wdata0_i;
    if (pick[1]) begin
      sel_we    = we1_i;
      sel_addr  = addr1_i;
      sel_wdata = wdata1_i;
    end
  end

  assign busy_o = (state != ST_IDLE);

  // Transaction FSM: accept in IDLE, drive the memory for one cycle in ISSUE,
  // then for reads capture data in RWAIT and pulse rvalid in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      winner    <= PORT_CPU;
      last_gnt  <= PORT_DMA;
      en_DM_rd  <= 1'b0;
      en_DM_wr  <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      gnt0_o    <= 1'b0;
      gnt1_o    <= 1'b0;
      rvalid0_o <= 1'b0;
      rvalid1_o <= 1'b0;
      rdata_o   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|pick) begin
            winner   <= pick[1];
            last_gnt <= pick[1];
            en_DM_rd <= ~sel_we;
            en_DM_wr <= sel_we;
            mem_addr <= sel_addr;
            mem_din  <= sel_wdata;
            gnt0_o   <= pick[0];
            gnt1_o   <= pick[1];
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // en_DM_rd still reflects the accepted command's direction here
          gnt0_o   <= 1'b0;
          gnt1_o   <= 1'b0;
          en_DM_rd <= 1'b0;
          en_DM_wr <= 1'b0;
          state    <= en_DM_rd ? ST_RWAIT : ST_IDLE;
        end
        ST_RWAIT: begin
          rdata_o   <= mem_dout;
          rvalid0_o <= (winner == PORT_CPU);
          rvalid1_o <= (winner == PORT_DMA);
          state     <= ST_RESP;
        end
        ST_RESP: begin
          rvalid0_o <= 1'b0;
          rvalid1_o <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
